instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Fetch stage directly downstream of the program counter. Each cycle it issues the current PC to a synchronous instruction memory and drives the program counter's enable. It captures each returned instruction with its PC in a small in-order queue. The queue presents entries to decode through a valid/ready handshake. A flush input discards all queued and in-flight fetches on a redirect (branch/jump taken).

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_W, 64, PC width
- INSTR_W, 32, instruction width
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; one clock, asynchronous, active-low
- pc  input  ADDR_W  current PC from program counter
- pc_enable  output  1  enable to program counter (PC loads its next value)
- imem_req  output  1  fetch request this cycle
- imem_addr  output  ADDR_W  fetch address; equals pc
- imem_rdata  input  INSTR_W  instruction data; valid exactly 1 cycle after imem_req
- flush  input  1  redirect; discard all queued/in-flight fetches
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out_instr  output  INSTR_W  head instruction
- out_pc  output  ADDR_W  PC of head instruction

## Operation
- State: storage[DEPTH] of {instr, pc}; wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH); count (0..DEPTH); inflight_v, inflight_pc.
- Occupancy = count + inflight_v. imem_req = !flush && occupancy < DEPTH. Credit check uses registered occupancy only; a same-cycle pop does not grant a credit.
- pc_enable = imem_req || flush. During flush, the PC loads the redirect target supplied by the external next-PC mux.
- On the edge with imem_req=1: inflight_v←1, inflight_pc←pc. Otherwise inflight_v←0.
- Push: on the edge where inflight_v=1 and flush=0, write {imem_rdata, inflight_pc} at wr_ptr; wr_ptr+1.
- Pop: out_valid = (count≠0). On the edge where out_valid && out_ready && !flush, rd_ptr+1.
- Simultaneous push and pop: count unchanged; both pointers advance. Push with count=DEPTH cannot occur (credit rule); verification asserts this.
- Pop while empty: ignored.
- Flush: on that edge, count←0, rd_ptr←wr_ptr←0, inflight_v←0. Returning data in the flush cycle is dropped. A concurrent pop is discarded. No request is issued in the flush cycle. Fetch resumes the following cycle from the new PC.
- out_instr/out_pc = storage[rd_ptr]. Contents are don't-care when out_valid=0, but storage resets to 0.

## Timing
- Reset (reset_n low, asynchronous): count=0, pointers=0, inflight_v=0, storage=0. Hence out_valid=0, out_instr=0, out_pc=0. imem_req and pc_enable are forced 0 while reset_n=0.
- First request is on the first edge after reset_n deasserts; imem_addr = pc (0 from the program counter's reset).
- Latency from request (cycle N) to out_valid=1 is 2 cycles: data returns in N+1 and is written at the end of N+1, so out_valid is asserted in N+2.
- Throughput with out_ready held high is 1 instruction/cycle; occupancy stays ≤2.
- With out_ready low, requests stop once occupancy=DEPTH. The PC holds (pc_enable=0) and resumes the cycle after the first pop lowers registered occupancy.
- Flush to first new out_valid: 3 cycles. The flush edge is followed by a request cycle, a data cycle, then valid.
- Asserting reset_n mid-operation clears all state immediately, including in-flight data.

## Test plan
- Reset: hold reset_n=0 with pc=0x40 and flush=0 -> out_valid=0, imem_req=0, pc_enable=0, out_pc=0. Release -> imem_req=1 on the first cycle.
- Streaming: memory returns pc>>2 for each PC, PC increments by 4, out_ready=1 -> out_valid rises 2 cycles after release. out_pc sequence 0,4,8,… and out_instr 0,1,2,… arrive one per cycle with no bubbles.
- Backpressure: out_ready=0 -> exactly 4 entries (PCs 0,4,8,12) are captured, imem_req falls, and the PC holds at 16. Raising out_ready drains 0,4,8,12 in order, then 16 follows with no loss or duplicate.
- Flush: with 3 queued and 1 in flight, pulse flush for 1 cycle with redirect target 0x100 -> out_valid=0 the next cycle and in-flight data is dropped. The next delivered entry has out_pc=0x100 and arrives 3 cycles after flush.
- Full with simultaneous pop: count=DEPTH, then one cycle of out_ready=1 -> head is popped, no push, and imem_req reasserts the next cycle. Order is preserved across pointer wrap (≥10 entries through a 4-deep queue).
- Async reset mid-stream: drop reset_n between clock edges during streaming -> out_valid, imem_req, and pc_enable go 0 without waiting for an edge. After release, fetching restarts at PC 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues pc to a synchronous instruction memory, queues returned
// {instr, pc} pairs in order, and hands them to decode over valid/ready.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_enable,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W+1:0] OCC_MAX = DEPTH[PTR_W+1:0];

  logic [INSTR_W-1:0] st_instr [DEPTH];
  logic [ADDR_W-1:0]  st_pc    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               inflight_v;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [PTR_W+1:0]   occupancy;
  logic               push, pop;

  // Credit is granted from registered occupancy only, so a pop in this cycle
  // frees a slot for a request in the next cycle, never the current one.
  always_comb begin
    occupancy = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight_v};
    imem_req  = reset_n && !flush && (occupancy < OCC_MAX);
    pc_enable = imem_req || (reset_n && flush);
    imem_addr = pc;
    out_valid = (count != '0);
    out_instr = st_instr[rd_ptr];
    out_pc    = st_pc[rd_ptr];
    push      = inflight_v && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight_v <= 1'b0;
    end else begin
      inflight_v <= imem_req;
      if (imem_req) inflight_pc <= pc;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_instr[i] <= '0;
        st_pc[i]    <= '0;
      end
    end else if (push) begin
      st_instr[wr_ptr] <= imem_rdata;
      st_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-based reference model plus a program
// counter and instruction memory environment, directed scenarios then random traffic.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] pc = '0;
  logic        pc_enable, imem_req, out_valid;
  logic [63:0] imem_addr, out_pc;
  logic [31:0] imem_rdata = '0, out_instr;
  logic        flush = 1'b0, out_ready = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .pc_enable(pc_enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
  ent_t        q[$];
  logic        m_infl;
  logic [63:0] m_infl_pc, m_pc;
  logic        e_valid, e_req, cur_rdy, cur_fl;
  logic [63:0] cur_tgt;
  int          total = 0, bad = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] s;
    s = a >> 2;
    return s[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_infl = 1'b0;
    m_infl_pc = '0;
    m_pc = '0;
  endtask

  // Drive one cycle's inputs after the falling edge and check all outputs.
  task automatic drive(input logic rdy, input logic fl, input logic [63:0] tgt);
    @(negedge clk);
    cur_rdy = rdy; cur_fl = fl; cur_tgt = tgt;
    out_ready = rdy;
    flush = fl;
    pc = m_pc;
    imem_rdata = m_infl ? mem_word(m_infl_pc) : $urandom;
    e_valid = (q.size() != 0);
    e_req = !fl && ((q.size() + int'(m_infl)) < DEPTH);
    #1;
    chk("imem_req", imem_req, e_req);
    chk("pc_enable", pc_enable, e_req || fl);
    chk("imem_addr", imem_addr, pc);
    chk("out_valid", out_valid, e_valid);
    if (e_valid) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
    end
  endtask

  task automatic advance();
    ent_t e;
    @(posedge clk);
    if (cur_fl) begin
      q.delete();
      m_infl = 1'b0;
      m_pc = cur_tgt;
    end else begin
      if (e_valid && cur_rdy) void'(q.pop_front());
      if (m_infl) begin
        e.instr = imem_rdata;
        e.pc = m_infl_pc;
        q.push_back(e);
      end
      if (q.size() > DEPTH) begin
        chk("queue_overflow", 64'(q.size()), 64'(DEPTH));
        void'(q.pop_back());
      end
      m_infl = e_req;
      m_infl_pc = m_pc;
      if (e_req) m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic cycle(input logic rdy, input logic fl, input logic [63:0] tgt);
    drive(rdy, fl, tgt);
    advance();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(rdy, 1'b0, '0);
  endtask

  // Hold reset with a non-zero pc on the bus; release away from an edge.
  task automatic hold_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pc = 64'h40; flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_pc_enable", pc_enable, 1'b0);
      chk("rst_out_pc", out_pc, 64'h0);
      chk("rst_out_instr", out_instr, 32'h0);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Streaming
    hold_reset(2);
    drive(1'b1, 1'b0, '0);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 64'h0);
    advance();
    drive(1'b1, 1'b0, '0); chk("lat_c1_valid", out_valid, 1'b0); advance();
    drive(1'b1, 1'b0, '0);
    chk("lat_c2_valid", out_valid, 1'b1);
    chk("lat_c2_pc", out_pc, 64'h0);
    chk("lat_c2_instr", out_instr, 32'h0);
    advance();
    drive(1'b1, 1'b0, '0); chk("stream_c3_pc", out_pc, 64'h4); advance();
    drive(1'b1, 1'b0, '0); chk("stream_c4_instr", out_instr, 32'h2); advance();

    // Asynchronous reset mid-stream
    drive(1'b1, 1'b0, '0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_req", imem_req, 1'b0);
    chk("async_pcen", pc_enable, 1'b0);
    hold_reset(1);
    drive(1'b1, 1'b0, '0); chk("restart_addr", imem_addr, 64'h0); advance();
    run(1, 1'b1);
    drive(1'b1, 1'b0, '0); chk("restart_pc", out_pc, 64'h0); advance();
    run(10, 1'b1);

    // Backpressure then drain
    hold_reset(1);
    run(7, 1'b0);
    drive(1'b0, 1'b0, '0);
    chk("bp_req", imem_req, 1'b0);
    chk("bp_pcen", pc_enable, 1'b0);
    chk("bp_pc_hold", imem_addr, 64'h10);
    chk("bp_head", out_pc, 64'h0);
    advance();
    run(4, 1'b1);
    drive(1'b1, 1'b0, '0); chk("drain_16", out_pc, 64'h10); advance();
    run(8, 1'b1);

    // Full with a single pop, then drain across pointer wrap
    hold_reset(1);
    run(8, 1'b0);
    drive(1'b1, 1'b0, '0);
    chk("full_pop_req", imem_req, 1'b0);
    chk("full_pop_head", out_pc, 64'h0);
    advance();
    drive(1'b0, 1'b0, '0);
    chk("credit_req", imem_req, 1'b1);
    chk("credit_head", out_pc, 64'h4);
    advance();
    run(20, 1'b1);

    // Flush with 3 queued and 1 in flight
    hold_reset(1);
    run(4, 1'b0);
    drive(1'b0, 1'b1, 64'h100);
    chk("flush_req", imem_req, 1'b0);
    chk("flush_pcen", pc_enable, 1'b1);
    advance();
    drive(1'b1, 1'b0, '0);
    chk("post_flush_valid", out_valid, 1'b0);
    chk("post_flush_addr", imem_addr, 64'h100);
    advance();
    run(1, 1'b1);
    drive(1'b1, 1'b0, '0);
    chk("flush_lat_valid", out_valid, 1'b1);
    chk("flush_lat_pc", out_pc, 64'h100);
    chk("flush_lat_instr", out_instr, 32'h40);
    advance();
    run(6, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      t[1:0] = 2'b00;
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
